// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: push/pop handshake and external RAM port bundle for sync_fifo_ctrl
// OVERFLOW/UNDERFLOW exist only when FIFO_ERR_FLAGS_EN is defined
interface sync_fifo_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
);
  logic              WR_EN;
  logic [DWIDTH-1:0] WR_DATA;
  logic              FULL;
  logic              RD_EN;
  logic [DWIDTH-1:0] RD_DATA;
  logic              RD_VALID;
  logic              EMPTY;
  logic [AWIDTH:0]   COUNT;
  logic              RAM_ENA;
  logic              RAM_WEA;
  logic [AWIDTH-1:0] RAM_ADDRA;
  logic [DWIDTH-1:0] RAM_DINA;
  logic              RAM_ENB;
  logic [AWIDTH-1:0] RAM_ADDRB;
  logic [DWIDTH-1:0] RAM_DOUTB;
`ifdef FIFO_ERR_FLAGS_EN
  logic              OVERFLOW;
  logic              UNDERFLOW;
  modport master (
    output WR_EN, WR_DATA, RD_EN, RAM_DOUTB,
    input  FULL, RD_DATA, RD_VALID, EMPTY, COUNT, RAM_ENA, RAM_WEA, RAM_ADDRA, RAM_DINA,
           RAM_ENB, RAM_ADDRB, OVERFLOW, UNDERFLOW
  );
  modport slave (
    input  WR_EN, WR_DATA, RD_EN, RAM_DOUTB,
    output FULL, RD_DATA, RD_VALID, EMPTY, COUNT, RAM_ENA, RAM_WEA, RAM_ADDRA, RAM_DINA,
           RAM_ENB, RAM_ADDRB, OVERFLOW, UNDERFLOW
  );
`else
  modport master (
    output WR_EN, WR_DATA, RD_EN, RAM_DOUTB,
    input  FULL, RD_DATA, RD_VALID, EMPTY, COUNT, RAM_ENA, RAM_WEA, RAM_ADDRA, RAM_DINA,
           RAM_ENB, RAM_ADDRB
  );
  modport slave (
    input  WR_EN, WR_DATA, RD_EN, RAM_DOUTB,
    output FULL, RD_DATA, RD_VALID, EMPTY, COUNT, RAM_ENA, RAM_WEA, RAM_ADDRA, RAM_DINA,
           RAM_ENB, RAM_ADDRB
  );
`endif
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: synchronous FIFO controller driving an external 1-cycle-latency dual-port RAM
// Optional sticky OVERFLOW/UNDERFLOW flags enabled by defining FIFO_ERR_FLAGS_EN
module sync_fifo_ctrl #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input logic          CLK,
  input logic          RSTN,
  sync_fifo_ctrl_if.slave bus
);
  logic [AWIDTH:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic            full_q, full_d, empty_q, empty_d, rd_valid_q, rd_valid_d;
  logic            push, pop;
`ifdef FIFO_ERR_FLAGS_EN
  logic            overflow_q, overflow_d, underflow_q, underflow_d;
`endif
  // RSTN gating keeps the RAM strobes quiet while reset is held
  always_comb begin
    push       = bus.WR_EN && !full_q && RSTN;
    pop        = bus.RD_EN && !empty_q && RSTN;
    wptr_d     = wptr_q + {{AWIDTH{1'b0}}, push};
    rptr_d     = rptr_q + {{AWIDTH{1'b0}}, pop};
    count_d    = wptr_d - rptr_d;
    empty_d    = wptr_d == rptr_d;
    full_d     = (wptr_d[AWIDTH-1:0] == rptr_d[AWIDTH-1:0]) && (wptr_d[AWIDTH] != rptr_d[AWIDTH]);
    rd_valid_d = pop;
`ifdef FIFO_ERR_FLAGS_EN
    overflow_d  = overflow_q || (bus.WR_EN && full_q && !pop);
    underflow_d = underflow_q || (bus.RD_EN && empty_q);
`endif
  end
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`endif
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
`ifdef FIFO_ERR_FLAGS_EN
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`endif
    end
  end
  assign bus.RAM_ENA   = push;
  assign bus.RAM_WEA   = push;
  assign bus.RAM_ADDRA = wptr_q[AWIDTH-1:0];
  assign bus.RAM_DINA  = bus.WR_DATA[DWIDTH-1:0];
  assign bus.RAM_ENB   = pop;
  assign bus.RAM_ADDRB = rptr_q[AWIDTH-1:0];
  assign bus.RD_DATA   = bus.RAM_DOUTB;
  assign bus.RD_VALID  = rd_valid_q;
  assign bus.EMPTY     = empty_q;
  assign bus.FULL      = full_q;
  assign bus.COUNT     = count_q;
`ifdef FIFO_ERR_FLAGS_EN
  assign bus.OVERFLOW  = overflow_q;
  assign bus.UNDERFLOW = underflow_q;
`endif
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed self-checking bench for sync_fifo_ctrl with a behavioural RAM
module tb_sync_fifo_ctrl;
  logic CLK = 1'b0;
  logic RSTN;
  int errors = 0;
  int checks = 0;
  logic [7:0] mem [4];

  sync_fifo_ctrl_if #(.DWIDTH(8), .AWIDTH(2)) b ();
  sync_fifo_ctrl #(.DWIDTH(8), .AWIDTH(2)) dut (.CLK(CLK), .RSTN(RSTN), .bus(b));

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (b.RAM_ENA && b.RAM_WEA) mem[b.RAM_ADDRA] <= b.RAM_DINA;
    if (b.RAM_ENB) b.RAM_DOUTB <= mem[b.RAM_ADDRB];
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; b.WR_EN = 1'b1; b.RD_EN = 1'b1; b.WR_DATA = 8'hEE;
    #1;
    checks++; if (b.RAM_ENA !== 1'b0 || b.RAM_WEA !== 1'b0) begin errors++; $display("FAIL rst_wr_strobe got %b/%b want 0/0", b.RAM_ENA, b.RAM_WEA); end
    checks++; if (b.RAM_ENB !== 1'b0) begin errors++; $display("FAIL rst_rd_strobe got %b want 0", b.RAM_ENB); end
    cyc(); cyc();
    checks++; if (b.COUNT !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", b.COUNT); end
    checks++; if (b.EMPTY !== 1'b1 || b.FULL !== 1'b0) begin errors++; $display("FAIL rst_flags got empty=%b full=%b want 1/0", b.EMPTY, b.FULL); end
    checks++; if (b.RD_VALID !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b want 0", b.RD_VALID); end
    b.WR_EN = 1'b0; b.RD_EN = 1'b0; RSTN = 1'b1;
    cyc();
  endtask

  task automatic test_push_pop();
    b.WR_EN = 1'b1; b.WR_DATA = 8'h11;
    #1;
    checks++; if (b.RAM_WEA !== 1'b1 || b.RAM_ADDRA !== 2'd0 || b.RAM_DINA !== 8'h11) begin errors++; $display("FAIL pp_write1 got wea=%b addr=%0d din=%h want 1/0/11", b.RAM_WEA, b.RAM_ADDRA, b.RAM_DINA); end
    cyc();
    checks++; if (b.COUNT !== 3'd1 || b.EMPTY !== 1'b0) begin errors++; $display("FAIL pp_count1 got count=%0d empty=%b want 1/0", b.COUNT, b.EMPTY); end
    b.WR_DATA = 8'h22;
    cyc();
    checks++; if (b.COUNT !== 3'd2) begin errors++; $display("FAIL pp_count2 got %0d want 2", b.COUNT); end
    b.WR_EN = 1'b0; b.RD_EN = 1'b1;
    #1;
    checks++; if (b.RAM_ENB !== 1'b1 || b.RAM_ADDRB !== 2'd0) begin errors++; $display("FAIL pp_rd_strobe got enb=%b addr=%0d want 1/0", b.RAM_ENB, b.RAM_ADDRB); end
    checks++; if (b.RD_VALID !== 1'b0) begin errors++; $display("FAIL pp_valid_early got %b want 0", b.RD_VALID); end
    cyc();
    checks++; if (b.RD_VALID !== 1'b1 || b.RD_DATA !== 8'h11) begin errors++; $display("FAIL pp_pop1 got valid=%b data=%h want 1/11", b.RD_VALID, b.RD_DATA); end
    cyc();
    checks++; if (b.RD_VALID !== 1'b1 || b.RD_DATA !== 8'h22) begin errors++; $display("FAIL pp_pop2 got valid=%b data=%h want 1/22", b.RD_VALID, b.RD_DATA); end
    checks++; if (b.COUNT !== 3'd0 || b.EMPTY !== 1'b1) begin errors++; $display("FAIL pp_drained got count=%0d empty=%b want 0/1", b.COUNT, b.EMPTY); end
    b.RD_EN = 1'b0;
    cyc();
    checks++; if (b.RD_VALID !== 1'b0) begin errors++; $display("FAIL pp_valid_drop got %b want 0", b.RD_VALID); end
  endtask

  task automatic test_full_overflow();
`ifdef FIFO_ERR_FLAGS_EN
    checks++; if (b.OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_initial got %b want 0", b.OVERFLOW); end
`endif
    b.WR_EN = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b.WR_DATA = 8'(i);
      cyc();
    end
    checks++; if (b.FULL !== 1'b1 || b.COUNT !== 3'd4) begin errors++; $display("FAIL full_set got full=%b count=%0d want 1/4", b.FULL, b.COUNT); end
    b.WR_DATA = 8'h55;
    #1;
    checks++; if (b.RAM_WEA !== 1'b0 || b.RAM_ENA !== 1'b0) begin errors++; $display("FAIL full_reject_strobe got wea=%b ena=%b want 0/0", b.RAM_WEA, b.RAM_ENA); end
    cyc();
    b.WR_EN = 1'b0;
    checks++; if (b.COUNT !== 3'd4 || b.FULL !== 1'b1) begin errors++; $display("FAIL full_hold got count=%0d full=%b want 4/1", b.COUNT, b.FULL); end
`ifdef FIFO_ERR_FLAGS_EN
    checks++; if (b.OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", b.OVERFLOW); end
    checks++; if (b.UNDERFLOW !== 1'b0) begin errors++; $display("FAIL unf_quiet got %b want 0", b.UNDERFLOW); end
`endif
  endtask

  task automatic test_full_both();
    b.WR_EN = 1'b1; b.RD_EN = 1'b1; b.WR_DATA = 8'h66;
    #1;
    checks++; if (b.RAM_WEA !== 1'b0 || b.RAM_ENB !== 1'b1) begin errors++; $display("FAIL fb_strobes got wea=%b enb=%b want 0/1", b.RAM_WEA, b.RAM_ENB); end
    cyc();
    b.WR_EN = 1'b0;
    checks++; if (b.COUNT !== 3'd3 || b.FULL !== 1'b0) begin errors++; $display("FAIL fb_count got count=%0d full=%b want 3/0", b.COUNT, b.FULL); end
    checks++; if (b.RD_VALID !== 1'b1 || b.RD_DATA !== 8'h01) begin errors++; $display("FAIL fb_data got valid=%b data=%h want 1/01", b.RD_VALID, b.RD_DATA); end
    for (int i = 2; i <= 4; i++) begin
      cyc();
      checks++; if (b.RD_DATA !== 8'(i) || b.RD_VALID !== 1'b1) begin errors++; $display("FAIL fb_drain%0d got valid=%b data=%h want 1/%h", i, b.RD_VALID, b.RD_DATA, 8'(i)); end
    end
    b.RD_EN = 1'b0;
    cyc();
    checks++; if (b.EMPTY !== 1'b1 || b.COUNT !== 3'd0) begin errors++; $display("FAIL fb_empty got empty=%b count=%0d want 1/0", b.EMPTY, b.COUNT); end
  endtask

  task automatic test_empty_both();
    b.WR_EN = 1'b1; b.RD_EN = 1'b1; b.WR_DATA = 8'hA5;
    #1;
    checks++; if (b.RAM_ENB !== 1'b0 || b.RAM_WEA !== 1'b1) begin errors++; $display("FAIL eb_strobes got enb=%b wea=%b want 0/1", b.RAM_ENB, b.RAM_WEA); end
    cyc();
    b.WR_EN = 1'b0;
    checks++; if (b.RD_VALID !== 1'b0 || b.COUNT !== 3'd1 || b.EMPTY !== 1'b0) begin errors++; $display("FAIL eb_state got valid=%b count=%0d empty=%b want 0/1/0", b.RD_VALID, b.COUNT, b.EMPTY); end
`ifdef FIFO_ERR_FLAGS_EN
    checks++; if (b.UNDERFLOW !== 1'b1) begin errors++; $display("FAIL unf_set got %b want 1", b.UNDERFLOW); end
`endif
    cyc();
    b.RD_EN = 1'b0;
    checks++; if (b.RD_VALID !== 1'b1 || b.RD_DATA !== 8'hA5 || b.COUNT !== 3'd0) begin errors++; $display("FAIL eb_pop got valid=%b data=%h count=%0d want 1/a5/0", b.RD_VALID, b.RD_DATA, b.COUNT); end
    cyc();
  endtask

  task automatic test_back_to_back();
    b.WR_EN = 1'b1; b.WR_DATA = 8'h01;
    cyc();
    b.RD_EN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b.WR_DATA = 8'(i + 2);
      cyc();
      checks++; if (b.RD_VALID !== 1'b1 || b.RD_DATA !== 8'(i + 1) || b.COUNT !== 3'd1) begin errors++; $display("FAIL stream%0d got valid=%b data=%h count=%0d want 1/%h/1", i, b.RD_VALID, b.RD_DATA, b.COUNT, 8'(i + 1)); end
    end
    b.WR_EN = 1'b0;
    cyc();
    b.RD_EN = 1'b0;
    checks++; if (b.RD_DATA !== 8'h0B || b.EMPTY !== 1'b1) begin errors++; $display("FAIL stream_tail got data=%h empty=%b want 0b/1", b.RD_DATA, b.EMPTY); end
    cyc();
  endtask

  task automatic test_reset_mid();
    b.WR_EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b.WR_DATA = 8'(8'hC1 + i);
      cyc();
    end
    b.WR_EN = 1'b0; b.RD_EN = 1'b1;
    cyc();
    b.RD_EN = 1'b0; RSTN = 1'b0; b.WR_EN = 1'b1; b.WR_DATA = 8'h99;
    #1;
    checks++; if (b.RAM_ENA !== 1'b0) begin errors++; $display("FAIL rm_strobe got %b want 0", b.RAM_ENA); end
    cyc();
    checks++; if (b.RD_VALID !== 1'b0 || b.COUNT !== 3'd0 || b.EMPTY !== 1'b1 || b.FULL !== 1'b0) begin errors++; $display("FAIL rm_state got valid=%b count=%0d empty=%b full=%b want 0/0/1/0", b.RD_VALID, b.COUNT, b.EMPTY, b.FULL); end
`ifdef FIFO_ERR_FLAGS_EN
    checks++; if (b.OVERFLOW !== 1'b0 || b.UNDERFLOW !== 1'b0) begin errors++; $display("FAIL rm_flags got ovf=%b unf=%b want 0/0", b.OVERFLOW, b.UNDERFLOW); end
`endif
    RSTN = 1'b1; b.WR_DATA = 8'h77;
    #1;
    checks++; if (b.RAM_WEA !== 1'b1 || b.RAM_ADDRA !== 2'd0) begin errors++; $display("FAIL rm_wptr got wea=%b addr=%0d want 1/0", b.RAM_WEA, b.RAM_ADDRA); end
    cyc();
    b.WR_EN = 1'b0; b.RD_EN = 1'b1;
    #1;
    checks++; if (b.RAM_ADDRB !== 2'd0) begin errors++; $display("FAIL rm_rptr got %0d want 0", b.RAM_ADDRB); end
    cyc();
    b.RD_EN = 1'b0;
    checks++; if (b.RD_VALID !== 1'b1 || b.RD_DATA !== 8'h77) begin errors++; $display("FAIL rm_pop got valid=%b data=%h want 1/77", b.RD_VALID, b.RD_DATA); end
  endtask

  initial begin
    b.WR_EN = 1'b0; b.RD_EN = 1'b0; b.WR_DATA = '0; RSTN = 1'b0;
    test_reset();
    test_push_pop();
    test_full_overflow();
    test_full_both();
    test_empty_both();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
